// File: rtl/pipeline_stage0_if.sv
// Fetch-stage bus bundle: redirect controls, program-memory port and stage outputs.
// No storage of its own; purely a set of wires shared between stage0 and its environment.
// master is the fetch stage; slave is the controller/memory side that drives it.
interface pipeline_stage0_if #(
  parameter int ADDR_WIDTH = 16
);
  // control inputs to the fetch stage
  logic                  bus_request;
  logic                  fetch_suppress;
  logic                  pc_load;
  logic                  ra_load;
  logic                  pcra_flip;
  logic [ADDR_WIDTH-1:0] load_value;

  // program memory port
  logic [7:0]            mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;

  // stage outputs
  logic [7:0]            instruction;
  logic [7:0]            operand;
  logic                  operand_valid;
  logic                  flag_pcraflip;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] ra;

  modport master (
    input  bus_request, fetch_suppress, pc_load, ra_load, pcra_flip, load_value,
    input  mem_data,
    output mem_addr, mem_rd,
    output instruction, operand, operand_valid, flag_pcraflip, pc, ra
  );

  modport slave (
    output bus_request, fetch_suppress, pc_load, ra_load, pcra_flip, load_value,
    output mem_data,
    input  mem_addr, mem_rd,
    input  instruction, operand, operand_valid, flag_pcraflip, pc, ra
  );
endinterface

// File: rtl/pipeline_stage0.sv
// Instruction fetch: owns PC/RA, drives program-memory address, registers opcode or operand byte.
// Latency: byte at address A appears on instruction one rising edge after PC = A; redirects cost one bubble.
// Backpressure: bus_request stalls fetch (HOLD) with no byte lost; bubbles (0x00) are emitted while stalled.
module pipeline_stage0 #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_stage0_if.master     bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]            NOP    = 8'h00;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [7:0]            instr_q, instr_d;
  logic [7:0]            operand_q, operand_d;
  logic                  opv_q, opv_d;
  logic                  flag_q, flag_d;

  // Sequential PC+1; wraps modulo 2^ADDR_WIDTH by construction.
  logic [ADDR_WIDTH-1:0] pc_plus1;
  assign pc_plus1 = pc_q + PC_ONE;

  // A flip only takes effect when no jump is requested in the same cycle.
  logic flip_take;
  assign flip_take = bus.pcra_flip && !bus.pc_load;

  // Next-state for FSM and datapath; instruction defaults to a bubble every cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ra_d      = ra_q;
    instr_d   = NOP;
    operand_d = operand_q;
    opv_d     = 1'b0;
    flag_d    = flag_q;

    case (state_q)
      ST_BOOT: begin
        // PC holds so the reset-vector byte is fetched on the first RUN edge.
        state_d = bus.bus_request ? ST_HOLD : ST_RUN;
      end

      ST_HOLD: begin
        // Bus belongs to the external master; everything freezes.
        if (!bus.bus_request) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.bus_request) begin
          // Stall entry: the byte at PC is not consumed, so nothing is lost.
          state_d = ST_HOLD;
        end else begin
          if (bus.pc_load) begin
            pc_d = bus.load_value;
          end else if (bus.pcra_flip) begin
            pc_d   = ra_q;
            flag_d = ~flag_q;
          end else begin
            pc_d = pc_plus1;
            if (bus.fetch_suppress) begin
              operand_d = bus.mem_data;
              opv_d     = 1'b1;
            end else begin
              instr_d = bus.mem_data;
            end
          end

          // The flip's return address outranks an explicit RA load.
          if (flip_take) begin
            ra_d = pc_plus1;
          end else if (bus.ra_load) begin
            ra_d = bus.load_value;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // All state registers; reset discards any in-flight stall or redirect at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      ra_q      <= '0;
      instr_q   <= NOP;
      operand_q <= 8'h00;
      opv_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ra_q      <= ra_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      opv_q     <= opv_d;
      flag_q    <= flag_d;
    end
  end

  // Memory is addressed straight from PC; reads are active outside HOLD.
  assign bus.mem_addr      = pc_q;
  assign bus.mem_rd        = (state_q != ST_HOLD);
  assign bus.instruction   = instr_q;
  assign bus.operand       = operand_q;
  assign bus.operand_valid = opv_q;
  assign bus.flag_pcraflip = flag_q;
  assign bus.pc            = pc_q;
  assign bus.ra            = ra_q;

endmodule
